// File: rtl/lighthouse_event_arbiter_pkg.sv
// lighthouse_defs: constants and FIFO word layout shared by the arbiter and the top-level hex printer
package lighthouse_defs;
    localparam logic [3:0] LH_TAG_BASE = 4'hA;
    localparam int LH_CHANNELS = 4;
    localparam int LH_ANGLE_WIDTH = 20;
    // field offsets measured upward from the top of the angle field
    localparam int LH_CHANNEL_OFS = 0;
    localparam int LH_TAG_OFS = 4;
endpackage

// File: rtl/lighthouse_event_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping to 0
module rr_arbiter #(
    parameter int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);
    logic hi_valid, lo_valid;
    logic [W-1:0] hi_idx, lo_idx;
    always_comb begin
        hi_valid = 1'b0;
        lo_valid = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        // descending scan so the lowest qualifying index is left standing
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_valid = 1'b1;
                lo_idx = W'(i);
            end
            if (req[i] && W'(i) >= ptr) begin
                hi_valid = 1'b1;
                hi_idx = W'(i);
            end
        end
        grant_valid = en && lo_valid;
        grant_idx = hi_valid ? hi_idx : lo_idx;
    end
endmodule

// File: rtl/lighthouse_event_arbiter.sv
// lighthouse_event_arbiter: per-slot one-deep holding registers drained round-robin into the timer FIFO
module lighthouse_event_arbiter
    import lighthouse_defs::*;
#(
    parameter int NUM_SENSORS = 4,
    parameter int ANGLE_WIDTH = LH_ANGLE_WIDTH,
    localparam int NUM_SLOTS = LH_CHANNELS * NUM_SENSORS,
    localparam int PW = $clog2(NUM_SLOTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_SLOTS*ANGLE_WIDTH-1:0] angle,
    input  logic [NUM_SLOTS-1:0]             strobe,
    input  logic                             fifo_full,
    output logic [8+ANGLE_WIDTH-1:0]         fifo_write,
    output logic                             fifo_write_strobe,
    output logic [15:0]                      overrun_count,
    output logic                             overrun
);
    logic [NUM_SLOTS-1:0] pend, grant_oh, lost;
    logic [ANGLE_WIDTH-1:0] hold [NUM_SLOTS];
    logic [PW-1:0] rr_ptr, grant_idx;
    logic grant_valid;
    logic [8+ANGLE_WIDTH-1:0] word;

    rr_arbiter #(.N(NUM_SLOTS)) u_rr (
        .req(pend),
        .ptr(rr_ptr),
        .en(!fifo_full),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx)
    );

    assign grant_oh = grant_valid ? (NUM_SLOTS'(1) << grant_idx) : '0;
    // a strobe on the slot being granted refills it and is not a drop
    assign lost = strobe & pend & ~grant_oh;

    always_comb begin
        word = '0;
        word[ANGLE_WIDTH-1:0] = hold[grant_idx];
        word[ANGLE_WIDTH+LH_CHANNEL_OFS +: 4] = 4'(grant_idx[1:0]);
        word[ANGLE_WIDTH+LH_TAG_OFS +: 4] = LH_TAG_BASE + 4'(grant_idx >> 2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) hold[s] <= '0;
            rr_ptr <= '0;
            fifo_write <= '0;
            fifo_write_strobe <= 1'b0;
            overrun <= 1'b0;
            overrun_count <= '0;
        end else begin
            pend <= (pend & ~grant_oh) | strobe;
            for (int s = 0; s < NUM_SLOTS; s++)
                if (strobe[s]) hold[s] <= angle[s*ANGLE_WIDTH +: ANGLE_WIDTH];
            fifo_write_strobe <= grant_valid;
            overrun <= |lost;
            if (|lost && overrun_count != 16'hFFFF) overrun_count <= overrun_count + 16'd1;
            if (grant_valid) begin
                fifo_write <= word;
                rr_ptr <= (32'(grant_idx) == NUM_SLOTS - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lighthouse_event_arbiter.sv
// tb_lighthouse_event_arbiter: directed scenarios plus random traffic against an event-level queue model
module tb_lighthouse_event_arbiter;
    localparam int SLOTS = 16;
    localparam int AW = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [SLOTS*AW-1:0] angle = '0;
    logic [SLOTS-1:0] strobe = '0;
    logic fifo_full = 1'b0;
    logic [27:0] fifo_write;
    logic fifo_write_strobe;
    logic [15:0] overrun_count;
    logic overrun;

    int errors = 0;
    int checks = 0;

    logic m_pend [SLOTS];
    logic [AW-1:0] m_hold [SLOTS];
    int m_ptr;
    logic [27:0] m_word;
    logic m_wstb, m_ovr;
    logic [15:0] m_cnt;

    lighthouse_event_arbiter dut (
        .clk(clk),
        .reset(reset),
        .angle(angle),
        .strobe(strobe),
        .fifo_full(fifo_full),
        .fifo_write(fifo_write),
        .fifo_write_strobe(fifo_write_strobe),
        .overrun_count(overrun_count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SLOTS; s++) begin
            m_pend[s] = 1'b0;
            m_hold[s] = '0;
        end
        m_ptr = 0;
        m_word = '0;
        m_wstb = 1'b0;
        m_ovr = 1'b0;
        m_cnt = '0;
    endtask

    task automatic set_angle(input int s, input logic [AW-1:0] v);
        angle[s*AW +: AW] = v;
    endtask

    // one clock: advance the model from the current inputs, then compare all outputs just after the edge
    task automatic tick();
        int g;
        logic lost;
        g = -1;
        if (!fifo_full)
            for (int i = 0; i < SLOTS; i++)
                if (g < 0 && m_pend[(m_ptr + i) % SLOTS]) g = (m_ptr + i) % SLOTS;
        lost = 1'b0;
        for (int s = 0; s < SLOTS; s++)
            if (strobe[s] && m_pend[s] && s != g) lost = 1'b1;
        m_wstb = (g >= 0);
        if (g >= 0) begin
            m_word = {4'hA + 4'(g / 4), 4'(g % 4), m_hold[g]};
            m_pend[g] = 1'b0;
            m_ptr = (g + 1) % SLOTS;
        end
        for (int s = 0; s < SLOTS; s++)
            if (strobe[s]) begin
                m_pend[s] = 1'b1;
                m_hold[s] = angle[s*AW +: AW];
            end
        m_ovr = lost;
        if (lost && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        @(posedge clk);
        #1;
        strobe = '0;
        check("wstb", 32'(fifo_write_strobe), 32'(m_wstb));
        check("word", 32'(fifo_write), 32'(m_word));
        check("ovr", 32'(overrun), 32'(m_ovr));
        check("ovr_cnt", 32'(overrun_count), 32'(m_cnt));
    endtask

    task automatic do_reset();
        #3 reset = 1'b0;
        #1;
        check("rst_word", 32'(fifo_write), 32'h0);
        check("rst_wstb", 32'(fifo_write_strobe), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_cnt", 32'(overrun_count), 32'h0);
        model_clear();
        strobe = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        do_reset();
        // single event, two-edge latency
        repeat (3) tick();
        set_angle(5, 20'h12345);
        strobe[5] = 1'b1;
        tick();
        check("single_early", 32'(fifo_write_strobe), 32'h0);
        tick();
        check("single_wstb", 32'(fifo_write_strobe), 32'h1);
        check("single_word", 32'(fifo_write), 32'hB112345);
        tick();
        check("single_once", 32'(fifo_write_strobe), 32'h0);
        // burst of four simultaneous strobes
        do_reset();
        for (int s = 0; s < 4; s++) begin
            set_angle(s, AW'(s + 1));
            strobe[s] = 1'b1;
        end
        tick();
        for (int s = 0; s < 4; s++) begin
            tick();
            check("burst_word", 32'(fifo_write), {4'h0, 4'hA, 4'(s), 20'(s + 1)});
        end
        tick();
        check("burst_done", 32'(fifo_write_strobe), 32'h0);
        // fairness between two always-busy slots
        do_reset();
        for (int c = 0; c < 12; c++) begin
            set_angle(2, AW'(c));
            set_angle(9, AW'(c + 100));
            strobe[2] = 1'b1;
            strobe[9] = 1'b1;
            tick();
            if (c >= 1) check("fair_slot", 32'(fifo_write[27:20]), (c % 2 == 1) ? 32'hA2 : 32'hC1);
        end
        // backpressure holds a pending event
        do_reset();
        fifo_full = 1'b1;
        set_angle(0, 20'h5A5A5);
        strobe[0] = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        fifo_full = 1'b0;
        tick();
        check("bp_wstb", 32'(fifo_write_strobe), 32'h1);
        check("bp_word", 32'(fifo_write), 32'hA05A5A5);
        // overrun while blocked
        do_reset();
        fifo_full = 1'b1;
        set_angle(7, 20'd100);
        strobe[7] = 1'b1;
        tick();
        set_angle(7, 20'd200);
        strobe[7] = 1'b1;
        tick();
        check("ovr_pulse", 32'(overrun), 32'h1);
        check("ovr_count", 32'(overrun_count), 32'h1);
        tick();
        fifo_full = 1'b0;
        tick();
        check("ovr_word", 32'(fifo_write), 32'hB3000C8);
        tick();
        check("ovr_single", 32'(fifo_write_strobe), 32'h0);
        // random traffic
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < SLOTS; s++) begin
                set_angle(s, AW'($urandom));
                strobe[s] = ($urandom_range(0, 5) == 0);
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        // reset in the middle of a burst
        fifo_full = 1'b1;
        for (int s = 0; s < 8; s++) begin
            set_angle(s, AW'(s + 7));
            strobe[s] = 1'b1;
        end
        tick();
        strobe[3] = 1'b1;
        fifo_full = 1'b0;
        tick();
        do_reset();
        for (int c = 0; c < 10; c++) tick();
        check("post_rst_idle", 32'(fifo_write_strobe), 32'h0);
        set_angle(12, 20'hFEDCB);
        strobe[12] = 1'b1;
        tick();
        tick();
        check("post_rst_word", 32'(fifo_write), 32'hD0FEDCB);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lighthouse_event_arbiter.md
# lighthouse_event_arbiter

Collects per-channel angle strobes from all `lighthouse_sensor` instances and serialises them into the shared 28-bit timer FIFO without losing simultaneous events. Each sensor/channel pair (slot) has a one-deep holding register. A round-robin scheduler issues at most one FIFO write per cycle and honours FIFO backpressure. The block sits between the sensor array and `fifo` and replaces ad-hoc priority muxing in the top level.

## Interface
- `NUM_SENSORS`, 4: sensor count, 1..16; slot count `NUM_SLOTS` = 4*NUM_SENSORS.
- `ANGLE_WIDTH`, 20: angle width in bits; the FIFO word is 8+ANGLE_WIDTH bits.
- `clk`  input  1  system clock (48 MHz).
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `angle`  input  NUM_SLOTS*ANGLE_WIDTH  flattened angles; slot s = sensor*4+channel occupies bits [s*ANGLE_WIDTH +: ANGLE_WIDTH].
- `strobe`  input  NUM_SLOTS  one-cycle pulse per slot; `angle` for that slot is valid in the same cycle.
- `fifo_full`  input  1  downstream FIFO cannot accept a write this cycle.
- `fifo_write`  output  8+ANGLE_WIDTH  word {tag[3:0], channel[3:0], angle}; tag = 4'hA + sensor, modulo 16.
- `fifo_write_strobe`  output  1  one-cycle write pulse.
- `overrun_count`  output  16  saturating count of dropped (overwritten) events.
- `overrun`  output  1  one-cycle pulse per dropped event.

## Operation
- The block holds per-slot registers `pend[s]` and `hold[s]` (ANGLE_WIDTH bits).
- Capture: on `strobe[s]`, set `hold[s]` <= `angle[s]` and `pend[s]` <= 1.
- Overrun: if `strobe[s]` arrives while `pend[s]`=1 and slot s is not granted this cycle:
  - the new angle overwrites `hold[s]`;
  - `overrun` pulses;
  - `overrun_count` increments and saturates at 16'hFFFF.
  - Multiple slots overrunning in one cycle count as one increment and one pulse. This is a documented limitation.
- Grant: when `fifo_full`=0 and any `pend` bit is set, grant the first pending slot at or after `rr_ptr`, scanning upward and wrapping at NUM_SLOTS-1 to 0.
- On a grant to slot g:
  - `fifo_write` <= {tag(g/4), g%4, hold[g]} and `fifo_write_strobe` <= 1;
  - `pend[g]` clears;
  - `rr_ptr` <= (g+1) mod NUM_SLOTS.
- Same-cycle grant and strobe on slot g: the old `hold[g]` is written, the new angle is captured, and `pend[g]` stays 1. This is not an overrun.
- `fifo_full`=1: no grant is made, `fifo_write_strobe`=0, and `pend`/`hold`/`rr_ptr` do not change except for captures.
- `fifo_write` holds its last value when no write is issued.
- Reset (asynchronous assert, synchronous release through the clock edge) clears:
  - all `pend` bits, all `hold` registers, `rr_ptr`;
  - `fifo_write` (0), `fifo_write_strobe` (0), `overrun` (0), `overrun_count` (0).
  - Events pending at reset are discarded. Reset mid-burst must not emit a partial or extra write.

## Timing
- Strobe sampled at edge k: `pend` is set after edge k.
- The earliest `fifo_write_strobe` is high in the cycle after edge k+1, so latency is 2 edges.
- Throughput: one write per cycle while `fifo_full`=0.
- N simultaneous strobes drain in N consecutive cycles.
- `fifo_full` is sampled combinationally in the grant cycle. The FIFO must present `fifo_full` for the cycle in which the write would land.
- Worst-case wait for a slot is NUM_SLOTS-1 grants after it becomes pending, provided there is no backpressure.
- Grant search is combinational across NUM_SLOTS (at most 64 slots). It must meet 48 MHz on the UP5K.

## Structure
- Shared package/include `lighthouse_defs` holds:
  - `LH_TAG_BASE`=4'hA, `LH_CHANNELS`=4, `LH_ANGLE_WIDTH`=20;
  - the FIFO word field offsets, shared with the hex-printer in top.
- Sub-module `rr_arbiter #(.N)`: inputs `req[N-1:0]`, `ptr`, `en`; outputs `grant_valid` and `grant_idx`. It is purely combinational.
- The parent owns `rr_ptr` and all state.

## Test plan
- Single event: `strobe[5]` with angle 20'h12345 at cycle 10, `fifo_full`=0 → one `fifo_write_strobe` at cycle 12 with word 28'hB1_12345; `overrun_count`=0.
- Burst: strobes on slots 0..3 in the same cycle, angles 1..4, `rr_ptr`=0 → four consecutive writes A0_00001, A1_00002, A2_00003, A3_00004, then `rr_ptr`=4.
- Fairness: slots 2 and 9 permanently re-strobed, `rr_ptr`=0 → grants alternate 2, 9, 2, 9 with no starvation.
- Backpressure: slot 0 pending and `fifo_full` held high for 20 cycles → no writes. Release → one write of the held value on the first free cycle.
- Overrun: `fifo_full`=1, two strobes on slot 7 (angles 100, 200) → `overrun` pulses once and `overrun_count`=1. After release, a single write with angle 200.
- Reset mid-operation: 8 slots pending, `reset` pulled low asynchronously between edges → outputs go to 0 immediately. After release, no writes occur until new strobes arrive.
